// File: rtl/booth_r4_mult_hs.sv
// booth_r4_mult_hs: sequential radix-4 Booth multiplier with valid/ready handshakes.
// One radix-4 digit (two multiplier bits) retires per clock; is_signed selects operand format.
// Optional feature macro: BOOTH_MAC_EN (p becomes a wrapping accumulator of products).
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are both high.
// in_ready is high only in IDLE and out_valid only in DONE, so exactly one transaction is
// in flight; in_valid during RUN/DONE and out_ready during IDLE/RUN have no effect.
module booth_r4_mult_hs #(
    parameter int A_WIDTH   = 6,
    parameter int B_WIDTH   = 6,
    parameter int ACC_GUARD = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [A_WIDTH-1:0]                   a,
    input  logic [B_WIDTH-1:0]                   b,
    input  logic                                 is_signed,
    input  logic                                 acc_clr,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [A_WIDTH+B_WIDTH+ACC_GUARD-1:0] p
);
    localparam int P_WIDTH   = A_WIDTH + B_WIDTH;
    localparam int OUT_WIDTH = P_WIDTH + ACC_GUARD;
    localparam int ITER      = (B_WIDTH + 2) / 2;
    localparam int HW        = A_WIDTH + 3;        // partial-product adder width
    localparam int LW        = 2 * ITER;           // product bits shifted out below the adder
    localparam int MW        = LW + 1;             // extended multiplier plus implicit 0 below bit 0
    localparam int CW        = $clog2(ITER + 1);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [HW-1:0]        a_q, a_d;      // multiplicand, extended to adder width
    logic [MW-1:0]        m_q, m_d;      // multiplier shift register, digit in [2:0]
    logic [HW-1:0]        hi_q, hi_d;    // upper partial product
    logic [LW-1:0]        lo_q, lo_d;    // low product bits collected from the shifts
    logic                 sgn_q, sgn_d;
    logic [OUT_WIDTH-1:0] p_q, p_d;

    logic                 last_step;
    logic [HW-1:0]        a2, dv, sum, hi_step;
    logic [LW-1:0]        lo_step;
    logic [P_WIDTH-1:0]   prod;
    logic [OUT_WIDTH-1:0] prod_ext;

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign p         = p_q;
    assign last_step = (state_q == S_RUN) && (cnt_q == LAST);

    // Booth digit decode, add into the upper partial product, then shift the pair right by 2.
    // The worst-case partial sum stays below 2^(A_WIDTH+2) in magnitude, so HW bits never overflow.
    always_comb begin
        a2 = {a_q[HW-2:0], 1'b0};
        dv = '0;
        case (m_q[2:0])
            3'b001, 3'b010: dv = a_q;
            3'b011:         dv = a2;
            3'b100:         dv = '0 - a2;
            3'b101, 3'b110: dv = '0 - a_q;
            default:        dv = '0;
        endcase
        sum      = hi_q + dv;
        hi_step  = {{2{sum[HW-1]}}, sum[HW-1:2]};
        lo_step  = {sum[1:0], lo_q[LW-1:2]};
        prod     = P_WIDTH'({hi_step, lo_step});
        prod_ext = {{ACC_GUARD{sgn_q & prod[P_WIDTH-1]}}, prod};
    end

    // Control FSM and operand/partial-product next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        m_d     = m_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        sgn_d   = sgn_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = {{(HW-A_WIDTH){is_signed & a[A_WIDTH-1]}}, a};
                    m_d     = {{(LW-B_WIDTH){is_signed & b[B_WIDTH-1]}}, b, 1'b0};
                    sgn_d   = is_signed;
                    hi_d    = '0;
                    lo_d    = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                hi_d  = hi_step;
                lo_d  = lo_step;
                m_d   = {{2{m_q[MW-1]}}, m_q[MW-1:2]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef BOOTH_MAC_EN
    logic clr_q;

    // Capture the accumulator-clear request together with the operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             clr_q <= 1'b0;
        else if (in_valid && state_q == S_IDLE) clr_q <= acc_clr;
    end

    // Accumulate once per transaction, on the RUN->DONE step; wraps modulo 2^OUT_WIDTH.
    always_comb begin
        p_d = p_q;
        if (last_step) p_d = (clr_q ? '0 : p_q) + prod_ext;
    end
`else
    logic unused_acc_clr;
    assign unused_acc_clr = acc_clr;

    // Result register loads the finished product and holds it until the next one.
    always_comb begin
        p_d = p_q;
        if (last_step) p_d = prod_ext;
    end
`endif

    // State and datapath registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            m_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            sgn_q   <= 1'b0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            m_q     <= m_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            sgn_q   <= sgn_d;
            p_q     <= p_d;
        end
    end

endmodule

// File: tb/tb_booth_r4_mult_hs.sv
// tb_booth_r4_mult_hs: directed and random checks for booth_r4_mult_hs (6x6, guard 4).
// Define BOOTH_MAC_EN to build both bench and design in accumulate mode.
module tb_booth_r4_mult_hs;
    localparam int AW   = 6;
    localparam int BW   = 6;
    localparam int GW   = 4;
    localparam int OW   = AW + BW + GW;
    localparam int ITER = (BW + 2) / 2;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic          is_signed;
    logic          acc_clr;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] p;

    int            errors = 0;
    int            checks = 0;
    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] acc_m = '0;

    booth_r4_mult_hs #(.A_WIDTH(AW), .B_WIDTH(BW), .ACC_GUARD(GW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .is_signed(is_signed), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .p(p)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Reference model: exact product of the interpreted operands, truncated to OW bits.
    function automatic logic [OW-1:0] ref_prod(input logic [AW-1:0] av, input logic [BW-1:0] bv,
                                               input logic sv);
        int x, y;
        x = sv ? int'($signed(av)) : int'(av);
        y = sv ? int'($signed(bv)) : int'(bv);
        return OW'(x * y);
    endfunction

    function automatic void push_expected(input logic [AW-1:0] av, input logic [BW-1:0] bv,
                                          input logic sv, input logic cv);
        logic [OW-1:0] e;
        e = ref_prod(av, bv, sv);
`ifdef BOOTH_MAC_EN
        acc_m = (cv ? '0 : acc_m) + e;
        exp_q.push_back(acc_m);
`else
        if (cv) acc_m = '0;
        exp_q.push_back(e);
`endif
    endfunction

    // Driver: present operands until accepted. Starts and ends just after a negedge.
    task automatic issue(input logic [AW-1:0] av, input logic [BW-1:0] bv, input logic sv,
                         input logic cv);
        int guard = 0;
        a = av; b = bv; is_signed = sv; acc_clr = cv; in_valid = 1'b1;
        while (!in_ready && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL issue_timeout: in_ready=%b after %0d cycles, required 1", in_ready, guard);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        push_expected(av, bv, sv, cv);
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom; b = $urandom; is_signed = $urandom; acc_clr = $urandom;
    endtask

    // Scoreboard drain: wait for a result, compare against the queue head, then consume it.
    task automatic consume(input string tag, output logic [OW-1:0] obs);
        int guard = 0;
        logic [OW-1:0] expv;
        obs = '0;
        while (!out_valid && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL %s_timeout: out_valid=%b after %0d cycles, required 1", tag, out_valid, guard);
            return;
        end
        obs = p;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_unexpected: got result p=%h, required no result", tag, p);
        end else begin
            expv = exp_q.pop_front();
            if (p !== expv) begin
                errors++;
                $display("FAIL %s: p=%h, required %h", tag, p, expv);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; is_signed = 1'b0; acc_clr = 1'b0;
        #12;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        checks++;
        if (p !== '0) begin errors++; $display("FAIL reset_p: got %h, required 0", p); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [AW-1:0] ta[7] = '{6'd32, 6'd63, 6'd32, 6'd0,  6'd31, 6'd63, 6'd63};
        logic [BW-1:0] tb[7] = '{6'd32, 6'd63, 6'd31, 6'd63, 6'd31, 6'd32, 6'd63};
        logic          ts[7] = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
        logic [OW-1:0] tp[7] = '{16'h0400, 16'h0F81, 16'hFC20, 16'h0000, 16'h03C1, 16'h07E0, 16'h0001};
        logic [OW-1:0] obs;
        int lat;
        for (int i = 0; i < 7; i++) begin
            issue(ta[i], tb[i], ts[i], 1'b1);
            if (i == 0) begin
                lat = 1;
                while (!out_valid && lat < 50) begin
                    @(negedge clk);
                    lat++;
                end
                lat--;
                checks++;
                if (lat !== ITER) begin
                    errors++;
                    $display("FAIL latency: out_valid after %0d cycles, required %0d", lat, ITER);
                end
            end
            consume("directed_sb", obs);
            checks++;
            if (obs !== tp[i]) begin
                errors++;
                $display("FAIL directed_%0d: p=%h, required %h", i, obs, tp[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [OW-1:0] held, obs;
        int guard = 0;
        issue(6'd45, 6'd22, 1'b0, 1'b1);
        while (!out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        held = (exp_q.size() > 0) ? exp_q[0] : '0;
        a = 6'd9; b = 6'd7; is_signed = 1'b1; acc_clr = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || p !== held) begin
                errors++;
                $display("FAIL stall_hold_%0d: out_valid=%b in_ready=%b p=%h, required 1 0 %h",
                         i, out_valid, in_ready, p, held);
            end
            @(negedge clk);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || p !== held) begin
            errors++;
            $display("FAIL stall_release: out_valid=%b in_ready=%b p=%h, required 0 1 %h",
                     out_valid, in_ready, p, held);
        end
        @(posedge clk);
        push_expected(6'd9, 6'd7, 1'b1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_queued_accept: in_ready=%b, required 0", in_ready);
        end
        consume("stall_queued", obs);
        checks++;
        if (obs !== 16'd63) begin errors++; $display("FAIL stall_queued_value: p=%h, required 003f", obs); end
    endtask

    task automatic test_reset_mid_run();
        logic [OW-1:0] obs;
        issue(6'd21, 6'd50, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL midrun_busy: in_ready=%b, required 0", in_ready); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || p !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrun_reset: out_valid=%b p=%h in_ready=%b, required 0 0000 1",
                     out_valid, p, in_ready);
        end
        exp_q.delete();
        acc_m = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midrun_ghost_%0d: out_valid=%b, required 0", i, out_valid);
            end
        end
        issue(6'd5, 6'd61, 1'b1, 1'b1);
        consume("midrun_after", obs);
        checks++;
        if (obs !== 16'hFFF1) begin errors++; $display("FAIL midrun_value: p=%h, required fff1", obs); end
    endtask

    task automatic test_random();
        int n_done = 0;
        fork
            begin
                for (int i = 0; i < 2000; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    issue(AW'($urandom), BW'($urandom), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 3) == 0));
                end
            end
            begin
                int guard = 0;
                logic [OW-1:0] expv;
                while (n_done < 2000 && guard < 60000) begin
                    @(negedge clk);
                    guard++;
                    out_ready = 1'($urandom_range(0, 1));
                    if (out_valid && out_ready) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL random_unexpected: p=%h, required no result", p);
                        end else begin
                            expv = exp_q.pop_front();
                            if (p !== expv) begin
                                errors++;
                                $display("FAIL random_%0d: p=%h, required %h", n_done, p, expv);
                            end
                        end
                        n_done++;
                    end
                end
                out_ready = 1'b0;
                if (n_done < 2000) begin
                    checks++; errors++;
                    $display("FAIL random_timeout: %0d results, required 2000", n_done);
                end
            end
        join
        @(negedge clk);
        out_ready = 1'b0;
    endtask

`ifdef BOOTH_MAC_EN
    task automatic test_mac();
        logic [OW-1:0] obs;
        issue(6'd3, 6'd4, 1'b0, 1'b1);
        consume("mac_1", obs);
        checks++;
        if (obs !== 16'd12) begin errors++; $display("FAIL mac_first: p=%h, required 000c", obs); end
        issue(6'd5, 6'd6, 1'b0, 1'b0);
        consume("mac_2", obs);
        checks++;
        if (obs !== 16'd42) begin errors++; $display("FAIL mac_accum: p=%h, required 002a", obs); end
        issue(6'd62, 6'd3, 1'b1, 1'b1);
        consume("mac_3", obs);
        checks++;
        if (obs !== 16'hFFFA) begin errors++; $display("FAIL mac_clear: p=%h, required fffa", obs); end
    endtask
`endif

    // Test sequence and final report.
    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_reset_mid_run();
        test_random();
`ifdef BOOTH_MAC_EN
        test_mac();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d expected results not produced, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
